// File: rtl/timer_pkg.sv
// Shared definitions for the hour/minute timekeeper and its CPU read responder.
// Holds the low-nibble address map, status bit positions and snapshot FSM states.
package timer_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned ADDR_W = 16;
  localparam int unsigned TIME_W = 6;

  // addr[3:0] codes, shared with the timer's write decode
  localparam logic [3:0] ADDR_HOUR = 4'h8;
  localparam logic [3:0] ADDR_MIN  = 4'h9;
  localparam logic [3:0] ADDR_STAT = 4'hA;

  // Status register bit positions
  localparam int unsigned TICK_BIT  = 0;
  localparam int unsigned STALE_BIT = 1;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    HELD = 1'b1
  } state_e;

endpackage

// File: rtl/time_readback_if.sv
// CPU read bus between a bus master and the time_readback responder.
//   r_en_n : read enable, active-low, one read per low cycle
//   addr   : CPU address, only addr[3:0] is decoded
//   rdata  : registered read data
//   rvalid : one-cycle strobe qualifying rdata
interface time_readback_if;
  import timer_pkg::*;

  logic                r_en_n;
  logic [ADDR_W-1:0]   addr;
  logic [DATA_W-1:0]   rdata;
  logic                rvalid;

  modport master (output r_en_n, output addr, input rdata, input rvalid);
  modport slave  (input r_en_n, input addr, output rdata, output rvalid);
endinterface

// File: rtl/time_readback.sv
// CPU-side read responder for the hour/minute timekeeper.
// Serves hour/minute/status reads, keeps an hour->minute snapshot so a
// two-read time fetch is coherent across rollover, and raises a sticky
// minute-tick flag with an optional level interrupt.
// Ports:
//   clock  : system clock
//   rst_n  : synchronous active-low reset
//   bus    : CPU read bus (slave side)
//   hour   : live hour from the timer, 0..23
//   minute : live minute from the timer, 0..59
//   irq    : level interrupt, tick flag AND IRQ_EN (registered)
module time_readback
  import timer_pkg::*;
#(
  parameter int unsigned HOLD_TIMEOUT = 255,
  parameter bit          IRQ_EN       = 1'b1
) (
  input  logic              clock,
  input  logic              rst_n,
  time_readback_if.slave    bus,
  input  logic [TIME_W-1:0] hour,
  input  logic [TIME_W-1:0] minute,
  output logic              irq
);

  localparam int unsigned CNT_W = 8;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_TIMEOUT - 1);

  // Registers
  state_e              r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic [DATA_W-1:0]   r_rdata;
  logic                r_rvalid;
  logic                r_irq;
  logic                r_tick;
  logic                r_stale;
  logic [TIME_W-1:0]   r_snap_hour;
  logic [TIME_W-1:0]   r_snap_min;
  logic [TIME_W-1:0]   r_prev_min;

  // Combinational next values
  state_e              w_state_nxt;
  logic [CNT_W-1:0]    w_cnt_nxt;
  logic [DATA_W-1:0]   w_rdata_nxt;
  logic                w_tick_nxt;
  logic                w_stale_nxt;
  logic                w_rd;
  logic                w_hour_rd;
  logic                w_min_rd;
  logic                w_stat_rd;
  logic                w_min_evt;
  logic [3:0]          w_code;
  logic                w_unused;

  assign w_code    = bus.addr[3:0];
  assign w_unused  = ^bus.addr[ADDR_W-1:4];
  assign w_rd      = ~bus.r_en_n;
  assign w_hour_rd = w_rd && (w_code == ADDR_HOUR);
  assign w_min_rd  = w_rd && (w_code == ADDR_MIN);
  assign w_stat_rd = w_rd && (w_code == ADDR_STAT);
  // Any minute change, whether a timer tick or a CPU write to the timer
  assign w_min_evt = (minute != r_prev_min);

  // Snapshot FSM state and hold counter
  always_ff @(posedge clock) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next-state, hold counter and read data mux
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_rdata_nxt = r_rdata;
    w_tick_nxt  = r_tick;
    w_stale_nxt = r_stale;

    case (r_state)
      IDLE: begin
        if (w_hour_rd) begin
          w_state_nxt = HELD;
          w_cnt_nxt   = '0;
        end
      end
      HELD: begin
        if (w_hour_rd) begin
          w_cnt_nxt = '0;
        end else if (w_min_rd || (r_cnt == CNT_LAST)) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
    endcase

    if (w_rd) begin
      case (w_code)
        ADDR_HOUR: w_rdata_nxt = {2'b00, hour};
        ADDR_MIN:  w_rdata_nxt = (r_state == HELD) ? {2'b00, r_snap_min}
                                                   : {2'b00, minute};
        ADDR_STAT: begin
          w_rdata_nxt            = '0;
          w_rdata_nxt[TICK_BIT]  = r_tick;
          w_rdata_nxt[STALE_BIT] = r_stale;
        end
        default:   w_rdata_nxt = '0;
      endcase
    end

    // Set wins over the read-clear of the tick flag
    w_tick_nxt = (w_stat_rd ? 1'b0 : r_tick) | w_min_evt;

    // A fresh snapshot clears stale even if the minute also changes now
    if (w_hour_rd) begin
      w_stale_nxt = 1'b0;
    end else if (w_min_evt && (r_state == HELD)) begin
      w_stale_nxt = 1'b1;
    end
  end

  // Read response, flags, snapshot and change-detection registers
  always_ff @(posedge clock) begin
    if (!rst_n) begin
      r_rdata     <= '0;
      r_rvalid    <= 1'b0;
      r_irq       <= 1'b0;
      r_tick      <= 1'b0;
      r_stale     <= 1'b0;
      r_snap_hour <= '0;
      r_snap_min  <= '0;
      r_prev_min  <= '0;
    end else begin
      r_rdata    <= w_rdata_nxt;
      r_rvalid   <= w_rd;
      r_irq      <= w_tick_nxt & IRQ_EN;
      r_tick     <= w_tick_nxt;
      r_stale    <= w_stale_nxt;
      r_prev_min <= minute;
      if (w_hour_rd) begin
        r_snap_hour <= hour;
        r_snap_min  <= minute;
      end
    end
  end

  assign bus.rdata  = r_rdata;
  assign bus.rvalid = r_rvalid;
  assign irq        = r_irq;

endmodule

// File: tb/tb_time_readback.sv
// Directed self-checking bench for time_readback.
// Inputs change on the falling edge; outputs are sampled on the next falling
// edge, i.e. half a cycle after the rising edge that registered them.
module tb_time_readback;
  import timer_pkg::*;

  localparam int unsigned HOLD_TIMEOUT = 255;

  logic       clock;
  logic       rst_n;
  logic [5:0] hour;
  logic [5:0] minute;
  logic       irq;

  time_readback_if bus ();

  time_readback #(
    .HOLD_TIMEOUT (HOLD_TIMEOUT),
    .IRQ_EN       (1'b1)
  ) dut (
    .clock  (clock),
    .rst_n  (rst_n),
    .bus    (bus),
    .hour   (hour),
    .minute (minute),
    .irq    (irq)
  );

  initial clock = 1'b0;
  always #50 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Issue one read at the current falling edge; return what the next edge registered
  task automatic do_read(input logic [3:0] code, output logic [7:0] d, output logic v);
    bus.r_en_n = 1'b0;
    bus.addr   = {12'h000, code};
    @(negedge clock);
    bus.r_en_n = 1'b1;
    d = bus.rdata;
    v = bus.rvalid;
  endtask

  logic [7:0] d;
  logic       v;

  initial begin
    rst_n      = 1'b0;
    bus.r_en_n = 1'b0;
    bus.addr   = 16'h0000;
    hour       = 6'd0;
    minute     = 6'd0;

    // Reset with a read held active
    repeat (2) @(negedge clock);
    check("rst_rvalid", 32'(bus.rvalid), 32'h0);
    check("rst_rdata",  32'(bus.rdata),  32'h00);
    check("rst_irq",    32'(irq),        32'h0);
    rst_n      = 1'b1;
    bus.r_en_n = 1'b1;
    do_read(ADDR_STAT, d, v);
    check("rst_stat_v", 32'(v), 32'h1);
    check("rst_stat",   32'(d), 32'h00);

    // Basic hour then minute on consecutive cycles
    hour = 6'd13; minute = 6'd45;
    do_read(4'h8, d, v);
    check("basic_hour_v", 32'(v), 32'h1);
    check("basic_hour",   32'(d), 32'h0D);
    do_read(4'h9, d, v);
    check("basic_min_v",  32'(v), 32'h1);
    check("basic_min",    32'(d), 32'h2D);
    @(negedge clock);
    check("idle_rvalid",  32'(bus.rvalid), 32'h0);
    check("idle_hold",    32'(bus.rdata),  32'h2D);
    check("basic_irq",    32'(irq),        32'h1);
    do_read(4'hA, d, v);
    check("basic_stat",   32'(d), 32'h01);
    check("basic_irq_clr", 32'(irq), 32'h0);

    // Rollover 23:59 -> 00:00 between the hour and minute reads
    hour = 6'd23; minute = 6'd59;
    @(negedge clock);
    do_read(4'h8, d, v);
    check("roll_hour", 32'(d), 32'h17);
    hour = 6'd0; minute = 6'd0;
    do_read(4'h9, d, v);
    check("roll_min",  32'(d), 32'h3B);
    check("roll_irq",  32'(irq), 32'h1);
    do_read(4'hA, d, v);
    check("roll_stat", 32'(d), 32'h03);
    check("roll_irq_clr", 32'(irq), 32'h0);

    // Minute read on the last held cycle still sees the snapshot
    hour = 6'd6; minute = 6'd7;
    @(negedge clock);
    do_read(4'h8, d, v);
    check("edge_hour", 32'(d), 32'h06);
    repeat (HOLD_TIMEOUT - 1) @(negedge clock);
    minute = 6'd8;
    do_read(4'h9, d, v);
    check("edge_min_snap", 32'(d), 32'h07);

    // One cycle later the snapshot has expired
    hour = 6'd5; minute = 6'd10;
    @(negedge clock);
    do_read(4'h8, d, v);
    check("to_hour", 32'(d), 32'h05);
    repeat (HOLD_TIMEOUT) @(negedge clock);
    minute = 6'd11;
    do_read(4'h9, d, v);
    check("to_min_live", 32'(d), 32'h0B);

    // Status read coinciding with a minute change returns the old tick
    minute = 6'd20;
    @(negedge clock);
    do_read(4'hA, d, v);
    check("sim_pre_tick", 32'(d[TICK_BIT]), 32'h1);
    minute = 6'd21;
    do_read(4'hA, d, v);
    check("sim_tick_old", 32'(d[TICK_BIT]), 32'h0);
    do_read(4'hA, d, v);
    check("sim_tick_new", 32'(d[TICK_BIT]), 32'h1);

    // Unmapped code
    do_read(4'hF, d, v);
    check("unmap_v", 32'(v), 32'h1);
    check("unmap_d", 32'(d), 32'h00);

    // Reset while a snapshot is held
    hour = 6'd2; minute = 6'd30;
    @(negedge clock);
    do_read(4'h8, d, v);
    check("rh_hour", 32'(d), 32'h02);
    minute = 6'd31;
    rst_n  = 1'b0;
    @(negedge clock);
    check("rh_rst_rdata",  32'(bus.rdata),  32'h00);
    check("rh_rst_rvalid", 32'(bus.rvalid), 32'h0);
    rst_n = 1'b1;
    do_read(4'h9, d, v);
    check("rh_min_live", 32'(d), 32'h1F);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
